// File: rtl/wb_pkg.sv
// Shared types and the load extractor for the writeback/retire stage.
// The struct widths follow the pipeline's datapath constants below.
package wb_pkg;

  localparam int WB_DBITS     = 32;
  localparam int WB_REGNOBITS = 5;

  // Load access size; encoding 3 is reserved and handled as a word.
  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  // Fields of the MEM latch that the retire stage consumes.
  typedef struct packed {
    logic                    valid;
    logic                    wr_reg;
    logic [WB_REGNOBITS-1:0] rd;
    logic                    is_load;
    logic [1:0]              ld_size;
    logic                    ld_unsigned;
    logic [WB_DBITS-1:0]     aluout;
    logic [WB_DBITS-1:0]     rdata;
  } mem_latch_t;

  // One register-file write: destination index and value.
  typedef struct packed {
    logic [WB_REGNOBITS-1:0] regno;
    logic [WB_DBITS-1:0]     data;
  } wr_rec_t;

  // Pick the addressed byte/half out of an aligned word and extend it.
  function automatic logic [WB_DBITS-1:0] load_extract(
    input logic [WB_DBITS-1:0] word,
    input logic [1:0]          off,
    input logic [1:0]          size,
    input logic                uns
  );
    logic [7:0]          b;
    logic [15:0]         h;
    logic [WB_DBITS-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      LD_B:    r = uns ? {{(WB_DBITS-8){1'b0}}, b} : {{(WB_DBITS-8){b[7]}}, b};
      LD_H:    r = uns ? {{(WB_DBITS-16){1'b0}}, h} : {{(WB_DBITS-16){h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous show-ahead FIFO for long-latency results. head always
// presents the oldest entry; a push while full and a pop while empty are
// both ignored.
module wb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: one registered register-file write port shared by
// the MEM latch and a FIFO of long-latency results. The pipeline wins the
// port; a FIFO entry blocked STARVE_MAX cycles in a row forces a one-cycle
// stall so the head can drain.
//
// lu_valid/lu_ready: a result transfers on a clock edge where both are high.
// The producer keeps lu_valid, lu_rd and lu_data stable until that edge;
// lu_ready depends only on registered FIFO occupancy.
module wb_retire_stage
  import wb_pkg::*;
#(
  parameter int DBITS      = WB_DBITS,
  parameter int REGNOBITS  = WB_REGNOBITS,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [DBITS-1:0]     mem_pc,
  input  logic                 mem_wr_reg,
  input  logic [REGNOBITS-1:0] mem_rd,
  input  logic                 mem_is_load,
  input  logic [1:0]           mem_ld_size,
  input  logic                 mem_ld_unsigned,
  input  logic [DBITS-1:0]     mem_aluout,
  input  logic [DBITS-1:0]     mem_rdata,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [REGNOBITS-1:0] lu_rd,
  input  logic [DBITS-1:0]     lu_data,
  output logic                 stall_req,
  output logic                 rf_we,
  output logic [REGNOBITS-1:0] rf_wregno,
  output logic [DBITS-1:0]     rf_wdata,
  output logic [31:0]          retired_count,
  output logic [DBITS-1:0]     reg10_val
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int RW = $bits(wr_rec_t);

  mem_latch_t     mem;
  logic [DBITS-1:0] pipe_result;
  logic           accept;
  logic           pipe_claim;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  wr_rec_t        push_rec;
  wr_rec_t        head_rec;
  logic [RW-1:0]  head_bits;
  wr_rec_t        grant_rec;
  logic           grant_valid;
  logic           do_write;
  logic [SW-1:0]  starve_cnt;
  logic           unused_pc;

  // The PC travels with the instruction for debug visibility only.
  assign unused_pc = ^mem_pc;

  assign mem = '{valid:       mem_valid,
                 wr_reg:      mem_wr_reg,
                 rd:          mem_rd,
                 is_load:     mem_is_load,
                 ld_size:     mem_ld_size,
                 ld_unsigned: mem_ld_unsigned,
                 aluout:      mem_aluout,
                 rdata:       mem_rdata};

  assign pipe_result = mem.is_load
                     ? load_extract(mem.rdata, mem.aluout[1:0], mem.ld_size, mem.ld_unsigned)
                     : mem.aluout;

  // Both handshake outputs come straight from registered state.
  assign stall_req  = (starve_cnt == SW'(STARVE_MAX));
  assign lu_ready   = !fifo_full;

  // Under a forced stall the MEM latch is ignored, so the head is free to pop.
  assign accept     = mem.valid && !stall_req;
  assign pipe_claim = accept && mem.wr_reg;
  assign fifo_pop   = !fifo_empty && !pipe_claim;
  assign fifo_push  = lu_valid && !fifo_full;
  assign push_rec   = '{regno: lu_rd, data: lu_data};
  assign head_rec   = wr_rec_t'(head_bits);

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port grant: the pipeline first, otherwise the FIFO head.
  always_comb begin
    grant_rec   = '0;
    grant_valid = 1'b0;
    if (pipe_claim) begin
      grant_rec   = '{regno: mem.rd, data: pipe_result};
      grant_valid = 1'b1;
    end else if (fifo_pop) begin
      grant_rec   = head_rec;
      grant_valid = 1'b1;
    end
  end

  // Writes to x0 still consume the grant (retire/pop) but never reach the file.
  assign do_write = grant_valid && (grant_rec.regno != '0);

  // Registered write port, retire counter and x10 shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we         <= 1'b0;
      rf_wregno     <= '0;
      rf_wdata      <= '0;
      retired_count <= '0;
      reg10_val     <= '0;
    end else begin
      rf_we <= do_write;
      if (do_write) begin
        rf_wregno <= grant_rec.regno;
        rf_wdata  <= grant_rec.data;
      end
      if (do_write && grant_rec.regno == REGNOBITS'(10)) reg10_val <= grant_rec.data;
      if (accept) retired_count <= retired_count + 32'd1;
    end
  end

  // Count consecutive cycles the waiting head lost the port to the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pipe_claim) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based
// reference model.
module tb_wb_retire_stage;

  localparam int DEPTH  = 4;
  localparam int SMAX   = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        mem_valid, mem_wr_reg, mem_is_load, mem_ld_unsigned;
  logic [31:0] mem_pc, mem_aluout, mem_rdata;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_ld_size;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        stall_req, rf_we;
  logic [4:0]  rf_wregno;
  logic [31:0] rf_wdata, retired_count, reg10_val;

  wb_retire_stage #(
    .DBITS(32), .REGNOBITS(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_wr_reg(mem_wr_reg), .mem_rd(mem_rd),
    .mem_is_load(mem_is_load), .mem_ld_size(mem_ld_size), .mem_ld_unsigned(mem_ld_unsigned),
    .mem_aluout(mem_aluout), .mem_rdata(mem_rdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .stall_req(stall_req), .rf_we(rf_we), .rf_wregno(rf_wregno), .rf_wdata(rf_wdata),
    .retired_count(retired_count), .reg10_val(reg10_val)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [36:0] exp_q[$];      // pending long-latency results {rd, data}
  int          m_starve = 0;
  logic [31:0] m_ret    = 0;
  logic [31:0] m_reg10  = 0;
  logic        m_we     = 0;
  logic [4:0]  m_wregno = 0;
  logic [31:0] m_wdata  = 0;

  // Load value by shifting/masking; sign extension via two's-complement wrap.
  function automatic logic [31:0] m_load(input logic [31:0] w, input int off,
                                         input int size, input bit uns);
    logic [31:0] v;
    if (size == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == 1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  bit          s_stall, s_claim, s_popped, s_empty, s_full, s_have;
  logic [4:0]  s_rd;
  logic [31:0] s_d;
  logic [36:0] s_ent;

  // Compare the DUT with the model mid-cycle, then advance the model across
  // the next rising edge using this cycle's inputs.
  always @(negedge clk) begin
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_wregno", 32'(rf_wregno), 32'(m_wregno));
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("retired_count", retired_count, m_ret);
    chk("reg10_val", reg10_val, m_reg10);
    chk("lu_ready", 32'(lu_ready), 32'(exp_q.size() < DEPTH));
    chk("stall_req", 32'(stall_req), 32'(m_starve == SMAX));

    if (reset) begin
      exp_q.delete();
      m_starve = 0; m_ret = 0; m_reg10 = 0; m_we = 0; m_wregno = 0; m_wdata = 0;
    end else begin
      s_stall  = (m_starve == SMAX);
      s_empty  = (exp_q.size() == 0);
      s_full   = (exp_q.size() == DEPTH);
      s_claim  = mem_valid && !s_stall && mem_wr_reg;
      s_have   = 0;
      s_popped = 0;
      s_rd     = 0;
      s_d      = 0;
      if (mem_valid && !s_stall) m_ret = m_ret + 1;
      if (s_claim) begin
        s_have = 1;
        s_rd   = mem_rd;
        s_d    = mem_is_load ? m_load(mem_rdata, int'(mem_aluout[1:0]), int'(mem_ld_size), mem_ld_unsigned)
                             : mem_aluout;
      end else if (!s_empty) begin
        s_ent    = exp_q.pop_front();
        s_popped = 1;
        s_have   = 1;
        s_rd     = s_ent[36:32];
        s_d      = s_ent[31:0];
      end
      if (s_popped || s_empty) m_starve = 0;
      else if (s_claim) m_starve = m_starve + 1;
      if (lu_valid && !s_full) exp_q.push_back({lu_rd, lu_data});
      m_we = s_have && (s_rd != 0);
      if (m_we) begin
        m_wregno = s_rd;
        m_wdata  = s_d;
        if (s_rd == 10) m_reg10 = s_d;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input bit v, input bit wr, input logic [4:0] rd, input bit ld,
                      input logic [1:0] sz, input bit uns, input logic [31:0] alu,
                      input logic [31:0] rdata);
    mem_valid = v; mem_wr_reg = wr; mem_rd = rd; mem_is_load = ld;
    mem_ld_size = sz; mem_ld_unsigned = uns; mem_aluout = alu; mem_rdata = rdata;
    mem_pc = mem_pc + 32'd4;
  endtask

  task automatic lu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  // Watchdog: the run must end on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] ret_save;
  int          first_stall;
  int          waited;
  bit          prev_stall;
  bit          lu_acc;

  initial begin
    reset  = 1'b1;
    mem_pc = 32'h0;
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);

    // Reset held for two edges.
    next_cycle();
    next_cycle();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_wregno", 32'(rf_wregno), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_retired", retired_count, 32'd0);
    chk("reset_reg10", reg10_val, 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    chk("reset_lu_ready", 32'(lu_ready), 32'd1);
    reset = 1'b0;
    next_cycle();
    chk("post_reset_rf_we", 32'(rf_we), 32'd0);

    // Loads from 0x80FF1234.
    pipe(1, 1, 7, 1, 2'd0, 0, 32'h1003, 32'h80FF1234);
    next_cycle();
    chk("lb_we", 32'(rf_we), 32'd1);
    chk("lb", rf_wdata, 32'hFFFFFF80);
    pipe(1, 1, 7, 1, 2'd0, 1, 32'h1003, 32'h80FF1234);
    next_cycle();
    chk("lbu", rf_wdata, 32'h00000080);
    pipe(1, 1, 7, 1, 2'd1, 0, 32'h1002, 32'h80FF1234);
    next_cycle();
    chk("lh", rf_wdata, 32'hFFFF80FF);
    pipe(1, 1, 7, 1, 2'd1, 1, 32'h1002, 32'h80FF1234);
    next_cycle();
    chk("lhu", rf_wdata, 32'h000080FF);
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Port conflict: pipeline write and FIFO push in the same cycle.
    pipe(1, 1, 3, 0, 0, 0, 32'h11, 0);
    lu(1, 5, 32'hAA);
    next_cycle();
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);
    chk("conflict_pipe_rd", 32'(rf_wregno), 32'd3);
    chk("conflict_pipe_data", rf_wdata, 32'h11);
    next_cycle();
    chk("conflict_lu_we", 32'(rf_we), 32'd1);
    chk("conflict_lu_rd", 32'(rf_wregno), 32'd5);
    chk("conflict_lu_data", rf_wdata, 32'hAA);
    next_cycle();

    // Starvation: one FIFO entry, pipeline writing every cycle.
    pipe(1, 1, 12, 0, 0, 0, 32'd0, 0);
    lu(1, 9, 32'hBEEF);
    first_stall = -1;
    prev_stall  = 0;
    ret_save    = 0;
    for (int i = 1; i <= 11; i++) begin
      next_cycle();
      lu(0, 0, 0);
      if (stall_req && first_stall < 0) first_stall = i;
      if (i == 9) ret_save = retired_count;
      if (i == 10) begin
        chk("starve_pop_rd", 32'(rf_wregno), 32'd9);
        chk("starve_pop_data", rf_wdata, 32'hBEEF);
        chk("starve_no_retire", retired_count, ret_save);
      end
      if (i == 11) begin
        chk("starve_held_data", rf_wdata, 32'd9);
        chk("starve_held_retire", retired_count, ret_save + 32'd1);
      end
      if (!prev_stall) pipe(1, 1, 12, 0, 0, 0, 32'(i), 0);
      prev_stall = stall_req;
    end
    chk("starve_cycle", 32'(first_stall), 32'd9);
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Full FIFO under continuous pipeline writes.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      pipe(1, 1, 3, 0, 0, 0, 32'(i), 0);
      lu(1, 5'(16 + i), 32'(100 + i));
    end
    next_cycle();
    pipe(1, 1, 3, 0, 0, 0, 32'd4, 0);
    lu(1, 5'd20, 32'd104);
    chk("full_lu_ready", 32'(lu_ready), 32'd0);
    waited = 0;
    while (!lu_ready && waited < 30) begin
      next_cycle();
      pipe(1, 1, 3, 0, 0, 0, 32'(5 + waited), 0);
      waited++;
    end
    chk("full_fifth_wait", 32'(waited), 32'd6);
    next_cycle();
    lu(0, 0, 0);
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) next_cycle();

    // x0 is dropped but retires; x10 is shadowed.
    ret_save = retired_count;
    pipe(1, 1, 0, 0, 0, 0, 32'h55, 0);
    next_cycle();
    pipe(1, 1, 10, 0, 0, 0, 32'h21, 0);
    chk("x0_no_write", 32'(rf_we), 32'd0);
    chk("x0_retires", retired_count, ret_save + 32'd1);
    next_cycle();
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x10_shadow", reg10_val, 32'h21);
    next_cycle();

    // Randomized traffic with a mid-run reset.
    prev_stall = 0;
    lu_acc     = 1;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      reset = (c >= 1500 && c < 1502);
      if (!prev_stall) begin
        pipe($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85,
             ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31)),
             $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom, $urandom);
      end
      if (!lu_valid || lu_acc) begin
        lu($urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom);
      end
      prev_stall = stall_req && !reset;
      lu_acc     = lu_valid && lu_ready;
    end
    reset = 1'b0;
    pipe(0, 0, 0, 0, 0, 0, 0, 0);
    lu(0, 0, 0);
    for (int i = 0; i < 10; i++) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
